// File: rtl/trace_packet_axis_streamer.sv
// trace_packet_axis_streamer: packs trace samples with cycle delta and event counts into an AXI-Stream FIFO
module trace_packet_axis_streamer #(
    parameter int XLEN                 = 64,
    parameter int INSTR_WIDTH          = 32,
    parameter int CLK_COUNTER_WIDTH    = 64,
    parameter int N_EVENTS             = 37,
    parameter int COUNTER_WIDTH        = 7,
    parameter int FIFO_DEPTH           = 4,
    parameter int WE_POSEDGE_TRIGGERED = 1,
    localparam int DATA_WIDTH = INSTR_WIDTH + CLK_COUNTER_WIDTH + XLEN + N_EVENTS * COUNTER_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [XLEN-1:0]              pc,
    input  logic [INSTR_WIDTH-1:0]       instr,
    input  logic                         write_enable,
    input  logic                         tlast_req,
    input  logic [31:0]                  tlast_interval,
    input  logic [N_EVENTS-1:0]          performance_events,
    input  logic [1:0]                   ctrl_addr,
    input  logic [CLK_COUNTER_WIDTH-1:0] ctrl_wdata,
    input  logic                         ctrl_we,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]        M_AXIS_tdata,
    output logic                         M_AXIS_tlast,
    output logic [15:0]                  drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                         ctrl_we_prev_q, ctrl_we_prev_d;
    logic [CLK_COUNTER_WIDTH-1:0] clk_counter_q, clk_counter_d;
    logic [CLK_COUNTER_WIDTH-1:0] last_ts_q, last_ts_d;
    logic [COUNTER_WIDTH-1:0]     cnt_q [N_EVENTS];
    logic [COUNTER_WIDTH-1:0]     cnt_d [N_EVENTS];
    logic [COUNTER_WIDTH-1:0]     snap [N_EVENTS];
    logic [31:0]                  beat_q, beat_d;
    logic [15:0]                  drop_q, drop_d;
    logic [DATA_WIDTH:0]          mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]          mem_d [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                  count_q, count_d;
    logic                         ctrl_wr, clr, full, pop, push, tag;
    logic [31:0]                  beat_inc;
    logic [DATA_WIDTH-1:0]        packet;

    // Snapshot counters including this cycle's events and pack the sample word
    always_comb begin
        packet = {instr, clk_counter_q - last_ts_q, pc, {(N_EVENTS * COUNTER_WIDTH){1'b0}}};
        for (int i = 0; i < N_EVENTS; i++) begin
            snap[i] = cnt_q[i] + COUNTER_WIDTH'(performance_events[i]);
            packet[(N_EVENTS - 1 - i) * COUNTER_WIDTH +: COUNTER_WIDTH] = snap[i];
        end
    end

    // Control writes, timestamps, event counters, framing and drop accounting
    always_comb begin
        ctrl_we_prev_d = ctrl_we;
        ctrl_wr        = (WE_POSEDGE_TRIGGERED != 0) ? (ctrl_we & ~ctrl_we_prev_q) : ctrl_we;
        clr            = ctrl_wr && ctrl_addr == 2'd2;
        clk_counter_d  = (ctrl_wr && ctrl_addr == 2'd0) ? ctrl_wdata : clk_counter_q + 1'b1;
        last_ts_d      = (ctrl_wr && ctrl_addr == 2'd1) ? ctrl_wdata : write_enable ? clk_counter_q : last_ts_q;
        for (int i = 0; i < N_EVENTS; i++) cnt_d[i] = (clr | write_enable) ? '0 : snap[i];
        beat_inc       = beat_q + 1'b1;
        tag            = tlast_req | (tlast_interval != 0 && beat_inc == tlast_interval);
        beat_d         = clr ? '0 : push ? (tag ? '0 : beat_inc) : beat_q;
        drop_d         = (write_enable & ~push & ~&drop_q) ? drop_q + 1'b1 : drop_q;
    end

    // Output queue: a full FIFO still accepts a push when the head pops in the same cycle
    always_comb begin
        full     = count_q == (AW + 1)'(FIFO_DEPTH);
        pop      = (count_q != '0) & M_AXIS_tready;
        push     = write_enable & (~full | pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {tag, packet};
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_we_prev_q <= 1'b0;
            clk_counter_q  <= '0;
            last_ts_q      <= '0;
            cnt_q          <= '{default: '0};
            beat_q         <= '0;
            drop_q         <= '0;
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            ctrl_we_prev_q <= ctrl_we_prev_d;
            clk_counter_q  <= clk_counter_d;
            last_ts_q      <= last_ts_d;
            cnt_q          <= cnt_d;
            beat_q         <= beat_d;
            drop_q         <= drop_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    assign M_AXIS_tvalid = count_q != '0;
    assign M_AXIS_tdata  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign M_AXIS_tlast  = mem_q[rd_ptr_q][DATA_WIDTH];
    assign drop_count    = drop_q;
endmodule

// File: tb/tb_trace_packet_axis_streamer.sv
// tb_trace_packet_axis_streamer: directed checks of packing, deltas, framing, drops and control writes
module tb_trace_packet_axis_streamer;
    localparam int NE = 37;
    localparam int CW = 7;
    localparam int DW = 32 + 64 + 64 + NE * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   pc = '0;
    logic [31:0]   instr = '0;
    logic          write_enable = 1'b0;
    logic          tlast_req = 1'b0;
    logic [31:0]   tlast_interval = '0;
    logic [NE-1:0] performance_events = '0;
    logic [1:0]    ctrl_addr = '0;
    logic [63:0]   ctrl_wdata = '0;
    logic          ctrl_we = 1'b0;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready = 1'b0;
    logic [DW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tlast;
    logic [15:0]   drop_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] edge_n = '0;
    logic [63:0] last_ts = '0;
    logic [63:0] exp_delta = '0;
    logic [63:0] d0 = '0;

    trace_packet_axis_streamer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .write_enable(write_enable),
        .tlast_req(tlast_req), .tlast_interval(tlast_interval), .performance_events(performance_events),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_we(ctrl_we),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata),
        .M_AXIS_tlast(M_AXIS_tlast), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] ins, input logic [63:0] d, input logic [63:0] p,
                                         input logic [CW-1:0] c0, input logic [CW-1:0] c2);
        logic [DW-1:0] r;
        r = '0;
        r[DW-1 -: 32]          = ins;
        r[DW-33 -: 64]         = d;
        r[DW-97 -: 64]         = p;
        r[(NE-1)*CW +: CW]     = c0;
        r[(NE-3)*CW +: CW]     = c2;
        return r;
    endfunction

    task automatic wr(input logic [63:0] p, input logic [31:0] ins, input logic req);
        pc = p;
        instr = ins;
        tlast_req = req;
        write_enable = 1'b1;
        exp_delta = edge_n - last_ts;
        last_ts = edge_n;
        tick();
        write_enable = 1'b0;
        tlast_req = 1'b0;
    endtask

    task automatic pop();
        M_AXIS_tready = 1'b1;
        tick();
        M_AXIS_tready = 1'b0;
    endtask

    task automatic ctrl(input logic [1:0] a, input logic [63:0] d, input int hold);
        ctrl_addr = a;
        ctrl_wdata = d;
        ctrl_we = 1'b1;
        repeat (hold) tick();
        ctrl_we = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        chk("rst_tvalid", M_AXIS_tvalid, 0);
        chk("rst_tdata", M_AXIS_tdata, 0);
        chk("rst_tlast", M_AXIS_tlast, 0);
        chk("rst_drop", drop_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        edge_n = '0;
        repeat (10) tick();
        wr(64'h1000, 32'h13, 1'b0);
        chk("first_tvalid", M_AXIS_tvalid, 1);
        chk("first_pkt", M_AXIS_tdata, mk(32'h13, 64'd10, 64'h1000, 0, 0));
        chk("first_tlast", M_AXIS_tlast, 0);
        pop();
        repeat (2) tick();
        performance_events[0] = 1'b1;
        repeat (4) tick();
        wr(64'h2000, 32'h23, 1'b0);
        performance_events[0] = 1'b0;
        wr(64'h3000, 32'h33, 1'b0);
        chk("ev0_pkt", M_AXIS_tdata, mk(32'h23, 64'd8, 64'h2000, 7'd5, 0));
        pop();
        chk("back2back_pkt", M_AXIS_tdata, mk(32'h33, 64'd1, 64'h3000, 0, 0));
        pop();
        performance_events[2] = 1'b1;
        repeat (129) tick();
        wr(64'h4000, 32'h43, 1'b0);
        performance_events[2] = 1'b0;
        chk("ev2_wrap_pkt", M_AXIS_tdata, mk(32'h43, exp_delta, 64'h4000, 0, 7'd2));
        pop();
        ctrl(2'd2, '0, 1);
        tlast_interval = 32'd3;
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr(64'h5000 + 64'(i), 32'h50 + 32'(i), i == 6);
            chk($sformatf("frame_tlast_%0d", i + 1), M_AXIS_tlast, (i == 2 || i == 5 || i == 6 || i == 9));
        end
        tick();
        M_AXIS_tready = 1'b0;
        chk("frame_drained", M_AXIS_tvalid, 0);
        tlast_interval = '0;
        for (int i = 0; i < 6; i++) begin
            wr(64'h6000 + 64'(i), 32'h60 + 32'(i), 1'b0);
            if (i == 0) d0 = exp_delta;
        end
        chk("drop_count", drop_count, 2);
        repeat (2) tick();
        chk("stall_stable", M_AXIS_tdata, mk(32'h60, d0, 64'h6000, 0, 0));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_tvalid_%0d", i), M_AXIS_tvalid, 1);
            chk($sformatf("drain_pkt_%0d", i), M_AXIS_tdata,
                mk(32'h60 + 32'(i), (i == 0) ? d0 : 64'd1, 64'h6000 + 64'(i), 0, 0));
            pop();
        end
        chk("drain_empty", M_AXIS_tvalid, 0);
        ctrl(2'd1, 64'd0, 1);
        ctrl_addr = 2'd0;
        ctrl_wdata = 64'd100;
        ctrl_we = 1'b1;
        repeat (3) tick();
        ctrl_we = 1'b0;
        wr(64'h7000, 32'h70, 1'b0);
        chk("ctrl_load_once", M_AXIS_tdata, mk(32'h70, 64'd102, 64'h7000, 0, 0));
        pop();
        wr(64'h8000, 32'h80, 1'b0);
        chk("pre_reset_tvalid", M_AXIS_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", M_AXIS_tvalid, 0);
        chk("async_rst_tdata", M_AXIS_tdata, 0);
        chk("async_rst_drop", drop_count, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/trace_packet_axis_streamer.md
# trace_packet_axis_streamer

Packs one execution-trace sample per write strobe (instruction, clock-cycle delta since the previous sample, PC, and per-event performance counts accumulated since the previous sample) into a wide word. The word is queued in a small FIFO and presented on an AXI4-Stream master port with programmable `tlast` framing. It sits between the trace filter / trigger logic of the monitoring system and the DMA-facing AXI-Stream FIFO. A level-or-edge control write port lets software load the internal timestamp registers.

## Interface
Parameters:
- `XLEN`, 64, PC width.
- `INSTR_WIDTH`, 32, instruction width.
- `CLK_COUNTER_WIDTH`, 64, width of the free-running clock counter and of the delta field.
- `N_EVENTS`, 37, number of performance-event inputs.
- `COUNTER_WIDTH`, 7, per-event counter width; counters wrap modulo 2^COUNTER_WIDTH.
- `FIFO_DEPTH`, 4, output queue entries (power of two, ≥2).
- `WE_POSEDGE_TRIGGERED`, 1, 1 = control write on rising edge of `ctrl_we`, 0 = every cycle `ctrl_we` is high.
- Derived `DATA_WIDTH` = INSTR_WIDTH + CLK_COUNTER_WIDTH + XLEN + N_EVENTS*COUNTER_WIDTH (419 by default).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  in  XLEN  sample PC.
- `instr`  in  INSTR_WIDTH  sample instruction.
- `write_enable`  in  1  capture a packet this cycle.
- `tlast_req`  in  1  force `tlast` on the packet captured this cycle.
- `tlast_interval`  in  32  packets per frame; 0 disables interval framing.
- `performance_events`  in  N_EVENTS  bit i high = event i occurs this cycle.
- `ctrl_addr`  in  2  control register select.
- `ctrl_wdata`  in  CLK_COUNTER_WIDTH  control write data.
- `ctrl_we`  in  1  control write strobe.
- `M_AXIS_tvalid`  out  1  FIFO non-empty.
- `M_AXIS_tready`  in  1  downstream ready.
- `M_AXIS_tdata`  out  DATA_WIDTH  head packet.
- `M_AXIS_tlast`  out  1  head packet ends a frame.
- `drop_count`  out  16  saturating count of packets lost to a full FIFO.

## Operation
- Edge detector: register `ctrl_we_d`; `ctrl_pos = ctrl_we & ~ctrl_we_d`. Write strobe = `ctrl_pos` or `ctrl_we` per `WE_POSEDGE_TRIGGERED`.
- Control writes:
  - addr 0 loads `clk_counter`.
  - addr 1 loads `last_write_timestamp`.
  - addr 2 clears all event counters and the frame beat counter.
  - addr 3 is ignored.
- `clk_counter` increments by 1 every cycle and wraps. A control load overrides the increment.
- Event counters: counter i increments on each cycle event bit i is high, modulo 2^COUNTER_WIDTH.
- On `write_enable`, event counter i is snapshotted as counter + event bit (mod), i.e. the snapshot includes the current cycle. All counters then go to 0 at that edge.
- Packet, MSB→LSB: `instr`, `delta`, `pc`, `cnt[0]` … `cnt[N_EVENTS-1]` (`cnt[0]` highest among counters).
- `delta` = `clk_counter` − `last_write_timestamp`, mod 2^CLK_COUNTER_WIDTH. On `write_enable`, `last_write_timestamp <= clk_counter`.
- Framing: a beat counter counts pushed packets. A packet is tagged `tlast` when either condition holds, and the beat counter resets to 0 after a tagged packet:
  - `tlast_req` is high; or
  - `tlast_interval` ≠ 0 and the beat count including this packet equals `tlast_interval`.
- The `tlast` tag is stored with the FIFO entry.
- FIFO push: accepted when not full, or when full but a pop occurs in the same cycle. Otherwise the packet is dropped, `drop_count` increments (saturating at 0xFFFF), and the beat counter is not advanced. The event counters and timestamp still reset/update on a dropped write.
- `M_AXIS_tvalid` = FIFO not empty. `tdata`/`tlast` come from the head entry. A pop occurs on `tvalid & tready`. `tdata`/`tlast` must not change while `tvalid & ~tready`.
- Simultaneous control write and `write_enable`:
  - The packet uses pre-write register values.
  - The control load wins for the targeted register.
  - A clear (addr 2) wins over the post-write counter reset (result 0 either way).

## Timing
- Reset values:
  - `tvalid` = 0, `tdata` = 0, `tlast` = 0, `drop_count` = 0.
  - FIFO empty; all counters, `clk_counter`, `last_write_timestamp`, beat counter and `ctrl_we_d` = 0.
- Reset asserted mid-operation discards FIFO contents immediately (asynchronously).
- Latency: `write_enable` at edge N makes the packet visible with `tvalid` = 1 after edge N, if the FIFO was empty.
- Consecutive `write_enable` cycles give `delta` = 1.
- The first write after reset gives `delta` = `clk_counter` value.
- Posedge mode: `ctrl_we` held high for k cycles performs exactly one write, on the first cycle.

## Test plan
- Reset release, `write_enable` pulse when `clk_counter` = 10, `pc`=0x1000, `instr`=0x13 → one beat with delta=10, pc=0x1000, instr=0x13, all counts 0, `tlast`=0.
- Event bit 0 high for 5 cycles including the write cycle, then a second write 8 cycles after the first → `cnt[0]`=5, delta=8. A third write immediately after → `cnt[0]`=0, delta=1.
- Event bit 2 high for 130 consecutive cycles, then write → `cnt[2]`=2 (130 mod 128).
- `tlast_interval`=3, 7 writes, `tready`=1 → `tlast` on beats 3 and 6. `tlast_req` on beat 7 → `tlast`=1 and beat counter restarts.
- `tready`=0, 6 consecutive writes → 4 queued, `drop_count`=2. Raising `tready` delivers 4 beats in order with stable data while stalled.
- `WE_POSEDGE_TRIGGERED`=1, addr 0, wdata=100, `ctrl_we` held 3 cycles → `clk_counter` reads 100 on the next edge and increments afterwards (loaded once, not reloaded).
